// File: rtl/reservation_station.sv
// -----------------------------------------------------------------------------
// reservation_station
//
// Out-of-order issue buffer. It holds dispatched micro-ops until both source
// operands are valid, wakes them up by snooping the common data bus (CDB),
// and issues the oldest ready micro-op to one execution unit.
//
// Parameters
//   RS_ENTRY    number of station entries
//   ROB_ENTRY   ROB depth; tags are ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY) bits
//   DATA_WIDTH  operand width
//   OP_WIDTH    micro-op code width
//
// Ports
//   CLK, RSTN                 clock (rising edge), async active-low reset
//   flush                     synchronous flush of every entry
//   disp_valid / disp_ready   dispatch handshake
//   disp_op, disp_rob_id      micro-op code and destination ROB tag
//   disp_srcN_rdy/tag/data    per-source: operand valid, producer tag, value
//   cdb_valid/id/data         result broadcast used for wakeup and bypass
//   iss_valid / iss_ready     issue handshake toward the execution unit
//   iss_op, iss_rob_id        issued micro-op code and ROB tag
//   iss_src1, iss_src2        issued operand values
//
// All outputs are functions of registered state only, so they settle right
// after each edge and follow an asynchronous reset immediately.
// -----------------------------------------------------------------------------
module reservation_station #(
    parameter  int RS_ENTRY       = 4,
    parameter  int ROB_ENTRY      = 4,
    parameter  int DATA_WIDTH     = 32,
    parameter  int OP_WIDTH       = 4,
    localparam int ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY)
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      flush,

    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [OP_WIDTH-1:0]       disp_op,
    input  logic [ROB_ENTRY_LOG2-1:0] disp_rob_id,
    input  logic                      disp_src1_rdy,
    input  logic [ROB_ENTRY_LOG2-1:0] disp_src1_tag,
    input  logic [DATA_WIDTH-1:0]     disp_src1_data,
    input  logic                      disp_src2_rdy,
    input  logic [ROB_ENTRY_LOG2-1:0] disp_src2_tag,
    input  logic [DATA_WIDTH-1:0]     disp_src2_data,

    input  logic                      cdb_valid,
    input  logic [ROB_ENTRY_LOG2-1:0] cdb_id,
    input  logic [DATA_WIDTH-1:0]     cdb_data,

    output logic                      iss_valid,
    input  logic                      iss_ready,
    output logic [OP_WIDTH-1:0]       iss_op,
    output logic [ROB_ENTRY_LOG2-1:0] iss_rob_id,
    output logic [DATA_WIDTH-1:0]     iss_src1,
    output logic [DATA_WIDTH-1:0]     iss_src2
);

    // -------------------------------------------------------------------------
    // Entry storage
    // -------------------------------------------------------------------------
    logic [RS_ENTRY-1:0]       r_valid;
    logic [RS_ENTRY-1:0]       r_src1_rdy;
    logic [RS_ENTRY-1:0]       r_src2_rdy;
    logic [OP_WIDTH-1:0]       r_op        [RS_ENTRY];
    logic [ROB_ENTRY_LOG2-1:0] r_rob_id    [RS_ENTRY];
    logic [ROB_ENTRY_LOG2-1:0] r_src1_tag  [RS_ENTRY];
    logic [ROB_ENTRY_LOG2-1:0] r_src2_tag  [RS_ENTRY];
    logic [DATA_WIDTH-1:0]     r_src1_data [RS_ENTRY];
    logic [DATA_WIDTH-1:0]     r_src2_data [RS_ENTRY];

    // Age matrix: r_older[i][j] = 1 means entry j was dispatched before entry i
    // and is still in the station. A row is loaded when its entry is written;
    // a column is cleared when its entry leaves.
    logic [RS_ENTRY-1:0]       r_older     [RS_ENTRY];

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic [RS_ENTRY-1:0] w_elig;        // valid with both operands ready
    logic [RS_ENTRY-1:0] w_sel;         // one-hot oldest eligible entry
    logic [RS_ENTRY-1:0] w_free;        // entry leaving through issue this cycle
    logic [RS_ENTRY-1:0] w_disp_hot;    // one-hot lowest free entry
    logic                w_iss_fire;
    logic                w_disp_fire;
    logic                w_byp1;
    logic                w_byp2;

    assign w_elig = r_valid & r_src1_rdy & r_src2_rdy;

    // Entries freed by issue this cycle are deliberately not counted, so the
    // dispatch target can never collide with the entry being issued.
    assign disp_ready = ~(&r_valid);

    // Lowest clear bit of r_valid: ~x & (x + 1) isolates it; all ones gives 0.
    assign w_disp_hot = ~r_valid & (r_valid + RS_ENTRY'(1));

    assign w_disp_fire = disp_valid & disp_ready & ~flush;

    // Dispatch-time bypass: the producer broadcasts while the consumer is being
    // written, so the value would otherwise be missed by the snoop logic.
    assign w_byp1 = ~disp_src1_rdy & cdb_valid & (cdb_id == disp_src1_tag);
    assign w_byp2 = ~disp_src2_rdy & cdb_valid & (cdb_id == disp_src2_tag);

    // An eligible entry is the oldest when no other eligible entry is older.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_sel = '0;
        for (int i = 0; i < RS_ENTRY; i++) begin
            w_sel[i] = w_elig[i] & ~(|(r_older[i] & w_elig));
        end
    end

    // Issue payload mux; it stays all-zero when nothing is selected.
    always_comb begin
        iss_op     = '0;
        iss_rob_id = '0;
        iss_src1   = '0;
        iss_src2   = '0;
        for (int i = 0; i < RS_ENTRY; i++) begin
            if (w_sel[i]) begin
                iss_op     = r_op[i];
                iss_rob_id = r_rob_id[i];
                iss_src1   = r_src1_data[i];
                iss_src2   = r_src2_data[i];
            end
        end
    end

    assign iss_valid  = |w_sel;
    assign w_iss_fire = iss_valid & iss_ready;
    assign w_free     = w_sel & {RS_ENTRY{w_iss_fire}};

    // -------------------------------------------------------------------------
    // State update
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            // NOTE: the payload arrays are reset as well so that every ready
            // bit and operand reads as zero straight out of reset.
            r_valid    <= '0;
            r_src1_rdy <= '0;
            r_src2_rdy <= '0;
            for (int i = 0; i < RS_ENTRY; i++) begin
                r_op[i]        <= '0;
                r_rob_id[i]    <= '0;
                r_src1_tag[i]  <= '0;
                r_src2_tag[i]  <= '0;
                r_src1_data[i] <= '0;
                r_src2_data[i] <= '0;
                r_older[i]     <= '0;
            end
        end else if (flush) begin
            // Flush wins over dispatch, snoop and issue; a handshake that
            // completes in this cycle is still taken by the execution unit.
            r_valid <= '0;
            for (int i = 0; i < RS_ENTRY; i++) begin
                r_older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_ENTRY; i++) begin
                // NOTE: non-blocking assignments throughout; a later write to
                // the same bit in this loop body (dispatch after free/snoop)
                // intentionally takes precedence.

                // Snoop: every waiting source of a live entry compares its tag.
                if (r_valid[i] && !r_src1_rdy[i] && cdb_valid &&
                    (cdb_id == r_src1_tag[i])) begin
                    r_src1_rdy[i]  <= 1'b1;
                    r_src1_data[i] <= cdb_data;
                end
                if (r_valid[i] && !r_src2_rdy[i] && cdb_valid &&
                    (cdb_id == r_src2_tag[i])) begin
                    r_src2_rdy[i]  <= 1'b1;
                    r_src2_data[i] <= cdb_data;
                end

                // Issue: the entry leaves, and nobody is younger than it anymore.
                if (w_free[i]) begin
                    r_valid[i] <= 1'b0;
                end
                r_older[i] <= r_older[i] & ~w_free;

                // Dispatch into the lowest free entry. It is younger than every
                // entry that survives this edge.
                if (w_disp_fire && w_disp_hot[i]) begin
                    r_valid[i]     <= 1'b1;
                    r_op[i]        <= disp_op;
                    r_rob_id[i]    <= disp_rob_id;
                    r_src1_tag[i]  <= disp_src1_tag;
                    r_src2_tag[i]  <= disp_src2_tag;
                    r_src1_rdy[i]  <= disp_src1_rdy | w_byp1;
                    r_src2_rdy[i]  <= disp_src2_rdy | w_byp2;
                    r_src1_data[i] <= disp_src1_rdy ? disp_src1_data : cdb_data;
                    r_src2_data[i] <= disp_src2_rdy ? disp_src2_data : cdb_data;
                    r_older[i]     <= r_valid & ~w_free;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Structural invariants
    // -------------------------------------------------------------------------
`ifndef SYNTHESIS
    a_sel_onehot : assert property (@(posedge CLK) disable iff (!RSTN)
        $onehot0(w_sel));
    a_sel_when_elig : assert property (@(posedge CLK) disable iff (!RSTN)
        (|w_elig) |-> (|w_sel));
`endif

endmodule

// File: tb/tb_reservation_station.sv
// -----------------------------------------------------------------------------
// tb_reservation_station
//
// Directed scenarios with a scoreboard: each expected issue is queued when the
// stimulus that should cause it is driven, and popped/compared whenever the
// DUT completes an issue handshake. Inputs change just after the falling edge;
// outputs (registered-state functions) are sampled there as well.
// -----------------------------------------------------------------------------
module tb_reservation_station;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [3:0]  disp_op;
    logic [1:0]  disp_rob_id;
    logic        disp_src1_rdy;
    logic [1:0]  disp_src1_tag;
    logic [31:0] disp_src1_data;
    logic        disp_src2_rdy;
    logic [1:0]  disp_src2_tag;
    logic [31:0] disp_src2_data;
    logic        cdb_valid;
    logic [1:0]  cdb_id;
    logic [31:0] cdb_data;
    logic        iss_valid;
    logic        iss_ready;
    logic [3:0]  iss_op;
    logic [1:0]  iss_rob_id;
    logic [31:0] iss_src1;
    logic [31:0] iss_src2;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  rob;
        logic [31:0] src1;
        logic [31:0] src2;
    } iss_t;

    iss_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    reservation_station dut (
        .CLK            (CLK),
        .RSTN           (RSTN),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_op        (disp_op),
        .disp_rob_id    (disp_rob_id),
        .disp_src1_rdy  (disp_src1_rdy),
        .disp_src1_tag  (disp_src1_tag),
        .disp_src1_data (disp_src1_data),
        .disp_src2_rdy  (disp_src2_rdy),
        .disp_src2_tag  (disp_src2_tag),
        .disp_src2_data (disp_src2_data),
        .cdb_valid      (cdb_valid),
        .cdb_id         (cdb_id),
        .cdb_data       (cdb_data),
        .iss_valid      (iss_valid),
        .iss_ready      (iss_ready),
        .iss_op         (iss_op),
        .iss_rob_id     (iss_rob_id),
        .iss_src1       (iss_src1),
        .iss_src2       (iss_src2)
    );

    // ---------------------------------------------------------------- helpers
    task automatic sb_pop_check();
        iss_t got;
        iss_t exp;
        got = '{op: iss_op, rob: iss_rob_id, src1: iss_src1, src2: iss_src2};
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL issue_unexpected: got op=%0h rob=%0d src1=%0h src2=%0h, required no issue",
                     got.op, got.rob, got.src1, got.src2);
        end else begin
            exp = sb_q.pop_front();
            if (got !== exp) begin
                n_fail++;
                $display("FAIL issue_payload: got op=%0h rob=%0d src1=%0h src2=%0h, required op=%0h rob=%0d src1=%0h src2=%0h",
                         got.op, got.rob, got.src1, got.src2, exp.op, exp.rob, exp.src1, exp.src2);
            end
        end
    endtask

    // Lets one rising edge happen; a handshake seen before it is scored.
    task automatic tick();
        if (iss_valid === 1'b1 && iss_ready === 1'b1) sb_pop_check();
        @(negedge CLK);
    endtask

    task automatic drive_disp(input logic [3:0] op, input logic [1:0] rob,
                              input logic r1, input logic [1:0] t1, input logic [31:0] d1,
                              input logic r2, input logic [1:0] t2, input logic [31:0] d2);
        disp_valid     = 1'b1;
        disp_op        = op;
        disp_rob_id    = rob;
        disp_src1_rdy  = r1;
        disp_src1_tag  = t1;
        disp_src1_data = d1;
        disp_src2_rdy  = r2;
        disp_src2_tag  = t2;
        disp_src2_data = d2;
    endtask

    task automatic drive_cdb(input logic v, input logic [1:0] id, input logic [31:0] d);
        cdb_valid = v;
        cdb_id    = id;
        cdb_data  = d;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        RSTN = 1'b0;
        flush = 1'b0;
        iss_ready = 1'b0;
        drive_disp(4'h0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 32'h0);
        disp_valid = 1'b0;
        drive_cdb(1'b0, 2'd0, 32'h0);
        #7;
        n_checks++;
        if (disp_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_disp_ready: got %b, required 1", disp_ready);
        end
        n_checks++;
        if (iss_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_iss_valid: got %b, required 0", iss_valid);
        end
        n_checks++;
        if ({iss_op, iss_rob_id, iss_src1, iss_src2} !== 70'd0) begin
            n_fail++; $display("FAIL reset_payload: got op=%0h rob=%0d s1=%0h s2=%0h, required all 0",
                               iss_op, iss_rob_id, iss_src1, iss_src2);
        end
        @(negedge CLK);
        RSTN = 1'b1;
    endtask

    // Dispatch on the first edge after reset release, both operands ready.
    task automatic test_ready_dispatch();
        iss_ready = 1'b1;
        drive_disp(4'd3, 2'd1, 1'b1, 2'd0, 32'h10, 1'b1, 2'd0, 32'h20);
        sb_q.push_back('{op: 4'd3, rob: 2'd1, src1: 32'h10, src2: 32'h20});
        tick();
        disp_valid = 1'b0;
        n_checks++;
        if (iss_valid !== 1'b1) begin
            n_fail++; $display("FAIL ready_iss_valid: got %b, required 1", iss_valid);
        end
        n_checks++;
        if (iss_rob_id !== 2'd1) begin
            n_fail++; $display("FAIL ready_rob_id: got %0d, required 1", iss_rob_id);
        end
        n_checks++;
        if (iss_src1 !== 32'h10 || iss_src2 !== 32'h20) begin
            n_fail++; $display("FAIL ready_srcs: got %0h/%0h, required 10/20", iss_src1, iss_src2);
        end
        tick();
        n_checks++;
        if (iss_valid !== 1'b0) begin
            n_fail++; $display("FAIL ready_drained: got %b, required 0", iss_valid);
        end
    endtask

    // Broadcast two cycles after dispatch; issue exactly one cycle later.
    task automatic test_wakeup();
        iss_ready = 1'b1;
        drive_disp(4'd5, 2'd2, 1'b0, 2'd2, 32'h0, 1'b1, 2'd0, 32'h77);
        tick();
        disp_valid = 1'b0;
        n_checks++;
        if (iss_valid !== 1'b0) begin
            n_fail++; $display("FAIL wakeup_early1: got %b, required 0", iss_valid);
        end
        tick();
        drive_cdb(1'b1, 2'd2, 32'hABCD);
        sb_q.push_back('{op: 4'd5, rob: 2'd2, src1: 32'hABCD, src2: 32'h77});
        n_checks++;
        if (iss_valid !== 1'b0) begin
            n_fail++; $display("FAIL wakeup_early2: got %b, required 0", iss_valid);
        end
        tick();
        drive_cdb(1'b0, 2'd0, 32'h0);
        n_checks++;
        if (iss_valid !== 1'b1 || iss_src1 !== 32'hABCD) begin
            n_fail++; $display("FAIL wakeup_issue: got valid=%b src1=%0h, required 1/abcd", iss_valid, iss_src1);
        end
        tick();
    endtask

    // Producer broadcasts in the dispatch cycle itself.
    task automatic test_bypass();
        iss_ready = 1'b1;
        drive_disp(4'd6, 2'd3, 1'b1, 2'd0, 32'h99, 1'b0, 2'd3, 32'hDEAD);
        drive_cdb(1'b1, 2'd3, 32'h55);
        sb_q.push_back('{op: 4'd6, rob: 2'd3, src1: 32'h99, src2: 32'h55});
        tick();
        disp_valid = 1'b0;
        drive_cdb(1'b0, 2'd0, 32'h0);
        n_checks++;
        if (iss_valid !== 1'b1 || iss_src2 !== 32'h55) begin
            n_fail++; $display("FAIL bypass_issue: got valid=%b src2=%0h, required 1/55", iss_valid, iss_src2);
        end
        tick();
    endtask

    // Fill, wake out of order, stall, then drain in dispatch order.
    task automatic test_full_backpressure();
        logic [1:0] wake_order [4];
        wake_order[0] = 2'd2; wake_order[1] = 2'd0; wake_order[2] = 2'd3; wake_order[3] = 2'd1;
        iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_disp(4'(8 + k), 2'(k), 1'b0, 2'(3 - k), 32'h0, 1'b1, 2'd0, 32'h200 + 32'(k));
            sb_q.push_back('{op: 4'(8 + k), rob: 2'(k), src1: 32'h1000 + 32'(3 - k), src2: 32'h200 + 32'(k)});
            tick();
        end
        disp_valid = 1'b0;
        n_checks++;
        if (disp_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_disp_ready: got %b, required 0", disp_ready);
        end
        for (int k = 0; k < 4; k++) begin
            drive_cdb(1'b1, wake_order[k], 32'h1000 + 32'(wake_order[k]));
            tick();
        end
        drive_cdb(1'b0, 2'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (iss_valid !== 1'b1 || iss_rob_id !== 2'd0) begin
                n_fail++; $display("FAIL stall_hold_%0d: got valid=%b rob=%0d, required 1/0", k, iss_valid, iss_rob_id);
            end
            tick();
        end
        iss_ready = 1'b1;
        n_checks++;
        if (disp_ready !== 1'b0) begin
            n_fail++; $display("FAIL first_issue_disp_ready: got %b, required 0", disp_ready);
        end
        tick();
        n_checks++;
        if (disp_ready !== 1'b1) begin
            n_fail++; $display("FAIL after_issue_disp_ready: got %b, required 1", disp_ready);
        end
        for (int k = 0; k < 3; k++) tick();
        n_checks++;
        if (iss_valid !== 1'b0) begin
            n_fail++; $display("FAIL full_drained: got %b, required 0", iss_valid);
        end
    endtask

    // A re-filled low index must still issue after older high-index entries.
    task automatic test_age_over_index();
        iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_disp(4'(1 + k), 2'(k), 1'b1, 2'd0, 32'h300 + 32'(k),
                       (k == 1), 2'd1, 32'h400 + 32'(k));
            tick();
        end
        disp_valid = 1'b0;
        sb_q.push_back('{op: 4'd2, rob: 2'd1, src1: 32'h301, src2: 32'h401});
        iss_ready = 1'b1;
        tick();
        n_checks++;
        if (disp_ready !== 1'b1) begin
            n_fail++; $display("FAIL age_disp_ready: got %b, required 1", disp_ready);
        end
        drive_disp(4'hE, 2'd1, 1'b1, 2'd0, 32'h3EE, 1'b0, 2'd1, 32'h0);
        tick();
        disp_valid = 1'b0;
        n_checks++;
        if (iss_valid !== 1'b0) begin
            n_fail++; $display("FAIL age_all_waiting: got %b, required 0", iss_valid);
        end
        drive_cdb(1'b1, 2'd1, 32'h4AA);
        sb_q.push_back('{op: 4'd1, rob: 2'd0, src1: 32'h300, src2: 32'h4AA});
        sb_q.push_back('{op: 4'd3, rob: 2'd2, src1: 32'h302, src2: 32'h4AA});
        sb_q.push_back('{op: 4'd4, rob: 2'd3, src1: 32'h303, src2: 32'h4AA});
        sb_q.push_back('{op: 4'hE, rob: 2'd1, src1: 32'h3EE, src2: 32'h4AA});
        tick();
        drive_cdb(1'b0, 2'd0, 32'h0);
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (iss_valid !== 1'b0) begin
            n_fail++; $display("FAIL age_drained: got %b, required 0", iss_valid);
        end
    endtask

    // Flush with 3 entries pending, an issue handshake and a dispatch attempt.
    task automatic test_flush();
        iss_ready = 1'b0;
        drive_disp(4'd7, 2'd0, 1'b1, 2'd0, 32'h500, 1'b1, 2'd0, 32'h501);
        tick();
        drive_disp(4'd7, 2'd1, 1'b0, 2'd1, 32'h0, 1'b1, 2'd0, 32'h511);
        tick();
        drive_disp(4'd7, 2'd2, 1'b0, 2'd2, 32'h0, 1'b1, 2'd0, 32'h521);
        tick();
        flush = 1'b1;
        iss_ready = 1'b1;
        drive_disp(4'hB, 2'd3, 1'b1, 2'd0, 32'hBAD, 1'b1, 2'd0, 32'hBAD);
        sb_q.push_back('{op: 4'd7, rob: 2'd0, src1: 32'h500, src2: 32'h501});
        tick();
        flush = 1'b0;
        disp_valid = 1'b0;
        n_checks++;
        if (disp_ready !== 1'b1 || iss_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_outputs: got disp_ready=%b iss_valid=%b, required 1/0", disp_ready, iss_valid);
        end
        for (int t = 0; t < 3; t++) begin
            drive_cdb(1'b1, 2'(t), 32'hF00 + 32'(t));
            tick();
            n_checks++;
            if (iss_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_stale_tag_%0d: got %b, required 0", t, iss_valid);
            end
        end
        drive_cdb(1'b0, 2'd0, 32'h0);
    endtask

    // RSTN pulsed low between edges; outputs must react without a clock.
    task automatic test_async_reset();
        iss_ready = 1'b0;
        drive_disp(4'd9, 2'd0, 1'b1, 2'd0, 32'h600, 1'b1, 2'd0, 32'h601);
        tick();
        drive_disp(4'd9, 2'd1, 1'b0, 2'd1, 32'h0, 1'b1, 2'd0, 32'h611);
        tick();
        drive_disp(4'd9, 2'd2, 1'b0, 2'd2, 32'h0, 1'b1, 2'd0, 32'h621);
        tick();
        disp_valid = 1'b0;
        n_checks++;
        if (iss_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_valid: got %b, required 1", iss_valid);
        end
        #2;
        RSTN = 1'b0;
        #1;
        n_checks++;
        if (disp_ready !== 1'b1 || iss_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_ctrl: got disp_ready=%b iss_valid=%b, required 1/0", disp_ready, iss_valid);
        end
        n_checks++;
        if ({iss_op, iss_rob_id, iss_src1, iss_src2} !== 70'd0) begin
            n_fail++; $display("FAIL async_reset_payload: got op=%0h rob=%0d s1=%0h s2=%0h, required all 0",
                               iss_op, iss_rob_id, iss_src1, iss_src2);
        end
        @(negedge CLK);
        RSTN = 1'b1;
        iss_ready = 1'b1;
        for (int t = 1; t < 3; t++) begin
            drive_cdb(1'b1, 2'(t), 32'hE00 + 32'(t));
            tick();
            n_checks++;
            if (iss_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_stale_tag_%0d: got %b, required 0", t, iss_valid);
            end
        end
        drive_cdb(1'b0, 2'd0, 32'h0);
        drive_disp(4'hC, 2'd2, 1'b1, 2'd0, 32'h700, 1'b1, 2'd0, 32'h701);
        sb_q.push_back('{op: 4'hC, rob: 2'd2, src1: 32'h700, src2: 32'h701});
        tick();
        disp_valid = 1'b0;
        n_checks++;
        if (iss_valid !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_dispatch: got %b, required 1", iss_valid);
        end
        tick();
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_bypass();
        test_full_backpressure();
        test_age_over_index();
        test_flush();
        test_async_reset();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d issues outstanding, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not reach its summary within the time limit");
        $fatal(1);
    end

endmodule
